id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised MIPS-subset decode stage with an integrated register file and a registered ID/EX output.
//  It sits between the IF stage (valid/ready) and the EX stage (valid/ready).
//  Per instruction it decodes the control fields, reads rs/rt, generates the immediate and selects the
//  destination register. It detects load-use hazards and inserts a bubble, and honours a branch flush.
// PARAMETERS
//  XLEN   32  datapath / register width
//  NREGS  32  architectural registers (2..32); AW = $clog2(NREGS)
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous active-low reset
//  if_valid      in   1     IF presents if_instr
//  if_instr      in   32    instruction word
//  id_ready      out  1     stage accepts if_instr this cycle
//  flush         in   1     kill ID/EX contents (branch taken)
//  ex_ready      in   1     EX accepts the ID/EX register this cycle
//  wb_we         in   1     writeback enable
//  wb_addr       in   AW    writeback register index
//  wb_data       in   XLEN  writeback data
//  ex_valid      out  1     ID/EX register holds a live instruction
//  ex_rs_data    out  XLEN  rs operand
//  ex_rt_data    out  XLEN  rt operand
//  ex_imm        out  XLEN  extended immediate
//  ex_dest       out  AW    destination index (0 when no write)
//  ex_opcode     out  6     opcode [31:26]
//  ex_funct      out  6     funct [5:0]
//  ex_ctrl       out  5     {reg_write, mem_read, mem_write, branch, jump}
//  ex_illegal    out  1     unrecognised opcode, or register index >= NREGS
// BEHAVIOUR
//  - Reset: all outputs 0; register file cleared to 0; id_ready follows the combinational rule below.
//  - Decode:
//    - R-type 000000: reads rs and rt; dest = rd.
//    - ADDI/SLTI/ANDI/ORI: read rs; dest = rt.
//    - LW/LB: read rs; dest = rt; mem_read = 1.
//    - SW/SB: read rs and rt; mem_write = 1; no write.
//    - BEQ/BNE: read rs and rt; branch = 1. BGEZ/BLTZ 000001: read rs; branch = 1.
//    - J 000010: jump = 1; imm = zero-extended [25:0].
//    - Any other opcode: ex_illegal = 1 and all ctrl bits = 0.
//  - Immediate: ANDI/ORI zero-extend [15:0]; all others sign-extend to XLEN.
//  - reg_write = (dest != 0). Register 0 always reads 0, and writes to it are dropped.
//  - Register file: written synchronously on the rising edge when wb_we = 1. Reads are combinational
//    and return the old value on a same-cycle read and write of the same index (no bypass).
//  - Advance: adv = !ex_valid | ex_ready. hazard = ex_valid & ex_mem_read & ex_dest != 0 & (ex_dest
//    matches a source register used by the decoding instruction).
//  - id_ready = adv & !hazard & !flush.
//  - On a clock edge, in priority order:
//    1. flush = 1: ex_valid <= 0.
//    2. adv & hazard: bubble (ex_valid <= 0, ex_ctrl <= 0), if_instr held.
//    3. adv & if_valid: load the ID/EX register, ex_valid <= 1.
//    4. adv & !if_valid: ex_valid <= 0.
//    5. Otherwise hold all ID/EX outputs.
//  - Latency: 1 cycle from acceptance to ex_valid. Throughput: 1 instruction per cycle without hazards.
//  - A load-use hazard costs exactly one bubble cycle.
//  - Reset asserted mid-operation discards the in-flight instruction and register contents immediately.
// CONFIGURATION
//  - ID_WB_BYPASS_EN defined: a same-cycle wb_we write to a source index is forwarded to
//    ex_rs_data/ex_rt_data, so the value written is captured.
//  - ID_WB_BYPASS_EN undefined: the old register value is captured; the pipeline must rely on
//    forwarding in EX.
// TESTING
//  - Reset, then ADDI $1,$0,-5 (0x2001FFFB) -> next cycle ex_valid = 1, ex_imm = 0xFFFFFFFB,
//    ex_dest = 1, ex_ctrl = 10000.
//  - ORI $2,$0,0x8000 -> ex_imm = 0x00008000 (zero-extended).
//  - wb writes $3 = 0x1234; then ADD $4,$3,$3 -> ex_rs_data = ex_rt_data = 0x1234, ex_dest = 4.
//  - LW $5,0($1) followed by ADD $6,$5,$0 -> id_ready = 0 for one cycle; one bubble (ex_valid = 0);
//    the ADD is issued next.
//  - ex_ready = 0 for 3 cycles -> ID/EX outputs stable and id_ready = 0. flush = 1 -> ex_valid = 0 on
//    the next edge.
//  - Opcode 111111 -> ex_illegal = 1, ex_ctrl = 0. wb write to $0 -> $0 still reads 0. With bypass on,
//    a same-cycle write is seen.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Handshake and datapath bundle between IF, the ID stage, EX and writeback.
// The ID stage takes the slave view; the driving environment takes the master view.
interface id_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            if_valid;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic            flush;
  logic            ex_ready;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_dest;
  logic [5:0]      ex_opcode;
  logic [5:0]      ex_funct;
  logic [4:0]      ex_ctrl;
  logic            ex_illegal;

  modport master (
    output if_valid, if_instr, flush, ex_ready, wb_we, wb_addr, wb_data,
    input  id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
           ex_opcode, ex_funct, ex_ctrl, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, flush, ex_ready, wb_we, wb_addr, wb_data,
    output id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_dest,
           ex_opcode, ex_funct, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-subset decode stage: register file, decode, load-use bubble, flush, registered ID/EX.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback into the captured operands.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           rst_n,
  id_stage_pipe_if.slave bus
);
  localparam int         AW     = $clog2(NREGS);
  localparam logic [5:0] NREGS6 = 6'(NREGS);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  logic [XLEN-1:0] r_rf [NREGS];

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_rs_data;
  logic [XLEN-1:0] r_ex_rt_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [AW-1:0]   r_ex_dest;
  logic [5:0]      r_ex_opcode;
  logic [5:0]      r_ex_funct;
  logic [4:0]      r_ex_ctrl;
  logic            r_ex_illegal;

  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic            w_use_rs;
  logic            w_use_rt;
  logic            w_dest_rd;
  logic            w_dest_rt;
  logic            w_mem_rd;
  logic            w_mem_wr;
  logic            w_br;
  logic            w_jmp;
  logic            w_zext;
  logic            w_bad_op;
  logic [4:0]      w_dest_raw;
  logic            w_idx_bad;
  logic            w_illegal;
  logic [4:0]      w_dest;
  logic [4:0]      w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs_rf;
  logic [XLEN-1:0] w_rt_rf;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic            w_wb_ok;
  logic            w_adv;
  logic            w_hazard;

  assign w_op = bus.if_instr[31:26];
  assign w_rs = bus.if_instr[25:21];
  assign w_rt = bus.if_instr[20:16];
  assign w_rd = bus.if_instr[15:11];

  always_comb begin
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_dest_rd = 1'b0;
    w_dest_rt = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_zext    = 1'b0;
    w_bad_op  = 1'b0;
    case (w_op)
      OP_RTYPE:         begin w_use_rs = 1'b1; w_use_rt = 1'b1; w_dest_rd = 1'b1; end
      OP_ADDI, OP_SLTI: begin w_use_rs = 1'b1; w_dest_rt = 1'b1; end
      OP_ANDI, OP_ORI:  begin w_use_rs = 1'b1; w_dest_rt = 1'b1; w_zext = 1'b1; end
      OP_LB, OP_LW:     begin w_use_rs = 1'b1; w_dest_rt = 1'b1; w_mem_rd = 1'b1; end
      OP_SB, OP_SW:     begin w_use_rs = 1'b1; w_use_rt = 1'b1; w_mem_wr = 1'b1; end
      OP_BEQ, OP_BNE:   begin w_use_rs = 1'b1; w_use_rt = 1'b1; w_br = 1'b1; end
      OP_REGIMM:        begin w_use_rs = 1'b1; w_br = 1'b1; end
      OP_J:             w_jmp = 1'b1;
      default:          w_bad_op = 1'b1;
    endcase
  end

  // An out-of-range register index is flagged and its write suppressed.
  assign w_dest_raw = w_dest_rd ? w_rd : (w_dest_rt ? w_rt : 5'd0);
  assign w_idx_bad  = (w_use_rs && ({1'b0, w_rs} >= NREGS6)) ||
                      (w_use_rt && ({1'b0, w_rt} >= NREGS6)) ||
                      ({1'b0, w_dest_raw} >= NREGS6);
  assign w_illegal  = w_bad_op || w_idx_bad;
  assign w_dest     = w_illegal ? 5'd0 : w_dest_raw;
  assign w_ctrl     = w_illegal ? 5'd0 : {(w_dest != 5'd0), w_mem_rd, w_mem_wr, w_br, w_jmp};

  assign w_imm = w_jmp  ? {{(XLEN-26){1'b0}}, bus.if_instr[25:0]} :
                 w_zext ? {{(XLEN-16){1'b0}}, bus.if_instr[15:0]} :
                          {{(XLEN-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

  assign w_rs_rf = (({1'b0, w_rs} < NREGS6) && (w_rs != 5'd0)) ? r_rf[w_rs[AW-1:0]] : '0;
  assign w_rt_rf = (({1'b0, w_rt} < NREGS6) && (w_rt != 5'd0)) ? r_rf[w_rt[AW-1:0]] : '0;

`ifdef ID_WB_BYPASS_EN
  assign w_rs_data = (w_wb_ok && (5'(bus.wb_addr) == w_rs)) ? bus.wb_data : w_rs_rf;
  assign w_rt_data = (w_wb_ok && (5'(bus.wb_addr) == w_rt)) ? bus.wb_data : w_rt_rf;
`else
  assign w_rs_data = w_rs_rf;
  assign w_rt_data = w_rt_rf;
`endif

  assign w_wb_ok = bus.wb_we && (bus.wb_addr != '0) && ({1'b0, 5'(bus.wb_addr)} < NREGS6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_ok) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign w_adv    = !r_ex_valid || bus.ex_ready;
  assign w_hazard = r_ex_valid && r_ex_ctrl[3] && (r_ex_dest != '0) &&
                    ((w_use_rs && (5'(r_ex_dest) == w_rs)) ||
                     (w_use_rt && (5'(r_ex_dest) == w_rt)));

  assign bus.id_ready = w_adv && !w_hazard && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_dest    <= '0;
      r_ex_opcode  <= '0;
      r_ex_funct   <= '0;
      r_ex_ctrl    <= '0;
      r_ex_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_adv && w_hazard) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
    end else if (w_adv && bus.if_valid) begin
      r_ex_valid   <= 1'b1;
      r_ex_rs_data <= w_rs_data;
      r_ex_rt_data <= w_rt_data;
      r_ex_imm     <= w_imm;
      r_ex_dest    <= w_dest[AW-1:0];
      r_ex_opcode  <= w_op;
      r_ex_funct   <= bus.if_instr[5:0];
      r_ex_ctrl    <= w_ctrl;
      r_ex_illegal <= w_illegal;
    end else if (w_adv) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_rs_data = r_ex_rs_data;
  assign bus.ex_rt_data = r_ex_rt_data;
  assign bus.ex_imm     = r_ex_imm;
  assign bus.ex_dest    = r_ex_dest;
  assign bus.ex_opcode  = r_ex_opcode;
  assign bus.ex_funct   = r_ex_funct;
  assign bus.ex_ctrl    = r_ex_ctrl;
  assign bus.ex_illegal = r_ex_illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed plus randomized bench for id_stage_pipe against an instruction-level reference model.
// Honours ID_WB_BYPASS_EN the same way the design does.
module tb_id_stage_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32), .NREGS(32)) bus ();
  id_stage_pipe #(.XLEN(32), .NREGS(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        v;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  ctrl;
    logic        ill;
  } ex_t;

  int          checks = 0;
  int          errors = 0;
  ex_t         m;
  logic [31:0] m_rf [32];
  logic        obs_ready;
  logic        last_acc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic ex_t dut_out();
    ex_t o;
    o = {bus.ex_valid, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_dest,
         bus.ex_opcode, bus.ex_funct, bus.ex_ctrl, bus.ex_illegal};
    return o;
  endfunction

  // Instruction-class view of the subset: which sources are read, what is written, side effects.
  function automatic void decode(input logic [31:0] ins, output logic urs, output logic urt,
                                 output logic [4:0] dest, output logic [4:0] ctrl,
                                 output logic ill, output logic [31:0] imm);
    logic mr, mw, br, jp;
    int   cls;
    case (ins[31:26])
      6'h00:                      cls = 1;
      6'h08, 6'h0A:               cls = 2;
      6'h0C, 6'h0D:               cls = 3;
      6'h20, 6'h23:               cls = 4;
      6'h28, 6'h2B:               cls = 5;
      6'h04, 6'h05:               cls = 6;
      6'h01:                      cls = 7;
      6'h02:                      cls = 8;
      default:                    cls = 0;
    endcase
    urs  = cls inside {1, 2, 3, 4, 5, 6, 7};
    urt  = cls inside {1, 5, 6};
    dest = (cls == 1) ? ins[15:11] : (cls inside {2, 3, 4}) ? ins[20:16] : 5'd0;
    mr   = (cls == 4);
    mw   = (cls == 5);
    br   = (cls == 6) || (cls == 7);
    jp   = (cls == 8);
    ill  = (cls == 0);
    ctrl = ill ? 5'd0 : {dest != 5'd0, mr, mw, br, jp};
    if (cls == 8)      imm = {6'd0, ins[25:0]};
    else if (cls == 3) imm = {16'd0, ins[15:0]};
    else               imm = {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    logic [31:0] val;
    val = (idx == 5'd0) ? 32'd0 : m_rf[idx];
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_we && idx != 5'd0 && bus.wb_addr == idx) val = bus.wb_data;
`endif
    return val;
  endfunction

  task automatic model_reset();
    m = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  task automatic step();
    logic        urs, urt, ill, adv, haz, rdy;
    logic [4:0]  dest, ctrl;
    logic [31:0] imm, ins;
    ex_t         nx;
    @(negedge clk);
    ins = bus.if_instr;
    decode(ins, urs, urt, dest, ctrl, ill, imm);
    adv = !m.v || bus.ex_ready;
    haz = m.v && m.ctrl[3] && m.dest != 5'd0 &&
          ((urs && ins[25:21] == m.dest) || (urt && ins[20:16] == m.dest));
    rdy = adv && !haz && !bus.flush;
    obs_ready = bus.id_ready;
    chk("id_ready", 128'(bus.id_ready), 128'(rdy));
    nx = m;
    if (bus.flush) nx.v = 1'b0;
    else if (adv && haz) begin nx.v = 1'b0; nx.ctrl = 5'd0; end
    else if (adv && bus.if_valid)
      nx = {1'b1, rf_read(ins[25:21]), rf_read(ins[20:16]), imm, dest,
            ins[31:26], ins[5:0], ctrl, ill};
    else if (adv) nx.v = 1'b0;
    last_acc = rdy && bus.if_valid;
    if (bus.wb_we && bus.wb_addr != 5'd0) m_rf[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    #1;
    m = nx;
    chk("ex_regs", 128'(dut_out()), 128'(m));
  endtask

  task automatic idle();
    bus.if_valid = 1'b0; bus.if_instr = 32'd0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
    bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic issue(input logic [31:0] ins);
    idle();
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    step();
  endtask

  logic [5:0] ops [14];

  initial begin
    ops = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
            6'h20, 6'h23, 6'h28, 6'h2B, 6'h3F};
    idle();
    model_reset();
    last_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 128'(dut_out()), 128'(0));
    chk("reset_ready", 128'(bus.id_ready), 128'(1));
    rst_n = 1'b1;

    issue(32'h2001FFFB);                              // ADDI $1,$0,-5
    chk("addi_valid", 128'(bus.ex_valid), 128'(1));
    chk("addi_imm", 128'(bus.ex_imm), 128'(32'hFFFFFFFB));
    chk("addi_dest", 128'(bus.ex_dest), 128'(1));
    chk("addi_ctrl", 128'(bus.ex_ctrl), 128'(5'b10000));

    issue(32'h34028000);                              // ORI $2,$0,0x8000
    chk("ori_imm", 128'(bus.ex_imm), 128'(32'h00008000));

    idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h1234;
    step();
    issue(32'h00632020);                              // ADD $4,$3,$3
    chk("add_rs", 128'(bus.ex_rs_data), 128'(32'h1234));
    chk("add_rt", 128'(bus.ex_rt_data), 128'(32'h1234));
    chk("add_dest", 128'(bus.ex_dest), 128'(4));

    issue(32'h8C250000);                              // LW $5,0($1)
    chk("lw_ctrl", 128'(bus.ex_ctrl), 128'(5'b11000));
    issue(32'h00A03020);                              // ADD $6,$5,$0 stalls once
    chk("hazard_ready", 128'(obs_ready), 128'(0));
    chk("hazard_bubble", 128'(bus.ex_valid), 128'(0));
    issue(32'h00A03020);
    chk("hazard_release", 128'(obs_ready), 128'(1));
    chk("hazard_issue_dest", 128'(bus.ex_dest), 128'(6));

    idle();
    bus.if_valid = 1'b1; bus.if_instr = 32'h34078001; bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 128'(obs_ready), 128'(0));
      chk("stall_dest", 128'(bus.ex_dest), 128'(6));
    end
    bus.flush = 1'b1;
    step();
    chk("flush_valid", 128'(bus.ex_valid), 128'(0));

    issue(32'hFC000000);
    chk("illegal_flag", 128'(bus.ex_illegal), 128'(1));
    chk("illegal_ctrl", 128'(bus.ex_ctrl), 128'(0));

    idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hDEADBEEF;
    step();
    issue(32'h00004820);                              // ADD $9,$0,$0
    chk("r0_zero", 128'(bus.ex_rs_data), 128'(0));

    idle();
    bus.if_valid = 1'b1; bus.if_instr = 32'h00E74020; // ADD $8,$7,$7
    bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000AAAA;
    step();
`ifdef ID_WB_BYPASS_EN
    chk("same_cycle_wb", 128'(bus.ex_rs_data), 128'(32'h0000AAAA));
`else
    chk("same_cycle_wb", 128'(bus.ex_rs_data), 128'(0));
`endif

    idle();
    last_acc = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (last_acc || !bus.if_valid) begin
        bus.if_instr = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
      end
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.wb_we    = ($urandom_range(0, 1) == 1);
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      step();
    end

    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_out", 128'(dut_out()), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(32'h00630820);                              // ADD $1,$3,$3 after reset
    chk("reset_rf_cleared", 128'(bus.ex_rs_data), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
